// File: rtl/ram_dp_sweep_pkg.sv
// Shared definitions for the swept dual-port data RAM: FSM state encoding and
// the legal read-latency range.
package ram_dp_sweep_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

   localparam int unsigned RD_LAT_MIN = 1;
   localparam int unsigned RD_LAT_MAX = 2;

   function automatic bit rd_lat_legal(input int unsigned lat);
      return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
   endfunction

endpackage

// File: rtl/ram_dp_sweep_rd_pipe.sv
// Optional second read-output register: carries data and valid, flushable.
// Data is only loaded with a valid beat so the output holds between reads.
module ram_rd_pipe #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  valid_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o
);

   logic [DATA_WIDTH-1:0] data_q;
   logic                  valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_i & ~flush_i;
         if (valid_i && !flush_i) begin
            data_q <= data_i;
         end
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/ram_dp_sweep.sv
// Simple-dual-port data RAM with a hardware clear sweep after reset or on request,
// a ready flag, 1- or 2-cycle read latency and selectable collision behaviour.
module ram_dp_sweep
   import ram_dp_sweep_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH  = 8,
   parameter int unsigned           ADDR_WIDTH  = 8,
   parameter int unsigned           RD_LATENCY  = 1,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
   parameter bit                    WRITE_FIRST = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   output logic                  ready,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   if (!rd_lat_legal(RD_LATENCY)) begin : g_bad_latency
      $error("ram_dp_sweep: RD_LATENCY must be 1 or 2");
   end

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  run, clr_go, wr_go, rd_go, collide;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] rd1_data_q, rd1_data_d;
   logic                  rd1_valid_q;

   // A clr request in RUN wins over any port access in the same cycle.
   assign run     = (state_q == ST_RUN);
   assign clr_go  = run & clr;
   assign wr_go   = run & wr_en & ~clr;
   assign rd_go   = run & rd_en & ~clr;
   assign collide = wr_go & (wr_addr == rd_addr);
   assign ready   = run;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_CLEAR;
         clr_ptr_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      unique case (state_q)
         ST_CLEAR: begin
            // The pointer parks on the last word; it never wraps back to 0.
            if (clr_ptr_q == '1) begin
               state_d = ST_RUN;
            end else begin
               clr_ptr_d = clr_ptr_q + 1'b1;
            end
         end
         ST_RUN: begin
            if (clr) begin
               state_d   = ST_CLEAR;
               clr_ptr_d = '0;
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = wr_addr;
      mem_wdata = wr_data;
      if (!run) begin
         mem_we    = 1'b1;
         mem_waddr = clr_ptr_q;
         mem_wdata = CLEAR_VALUE;
      end else if (wr_go) begin
         mem_we = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   // Array read sees pre-edge contents, so read-first needs no extra path.
   always_comb begin
      rd1_data_d = mem[rd_addr];
      if (WRITE_FIRST && collide) begin
         rd1_data_d = wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd1_data_q  <= '0;
         rd1_valid_q <= 1'b0;
      end else begin
         rd1_valid_q <= rd_go;
         if (rd_go) begin
            rd1_data_q <= rd1_data_d;
         end
      end
   end

   if (RD_LATENCY == 2) begin : g_lat2
      ram_rd_pipe #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_rd_pipe (
         .clk     (clk),
         .rst_n   (rst_n),
         .flush_i (clr_go),
         .data_i  (rd1_data_q),
         .valid_i (rd1_valid_q),
         .data_o  (rd_data),
         .valid_o (rd_valid)
      );
   end else begin : g_lat1
      assign rd_data  = rd1_data_q;
      assign rd_valid = rd1_valid_q;
   end

endmodule

// File: tb/tb_ram_dp_sweep.sv
// Scoreboard bench: two RAM instances (latency 1 / write-first, latency 2 / read-first)
// share stimulus; a behavioural memory model predicts ready and every read result.
module tb_ram_dp_sweep;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       clr   = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_addr = 8'h00;
   logic [7:0] wr_data = 8'h00;
   logic       rd_en = 1'b0;
   logic [7:0] rd_addr = 8'h00;

   logic       ready_a, ready_b, rd_valid_a, rd_valid_b;
   logic [7:0] rd_data_a, rd_data_b;

   always #5 clk = ~clk;

   ram_dp_sweep #(
      .DATA_WIDTH  (8),
      .ADDR_WIDTH  (8),
      .RD_LATENCY  (1),
      .CLEAR_VALUE (8'h00),
      .WRITE_FIRST (1'b1)
   ) u_dut_a (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .ready    (ready_a),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data_a),
      .rd_valid (rd_valid_a)
   );

   ram_dp_sweep #(
      .DATA_WIDTH  (8),
      .ADDR_WIDTH  (8),
      .RD_LATENCY  (2),
      .CLEAR_VALUE (8'h00),
      .WRITE_FIRST (1'b0)
   ) u_dut_b (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .ready    (ready_b),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data_b),
      .rd_valid (rd_valid_b)
   );

   typedef struct packed {
      logic [7:0]  data;
      logic [31:0] due;
   } exp_t;

   // Reference model state
   logic [7:0]  m_mem [256];
   logic        m_ready    = 1'b0;
   int          sweep_left = 256;
   int unsigned cyc        = 0;
   exp_t        qa[$];
   exp_t        qb[$];
   logic [7:0]  last_a = 8'h00;
   logic [7:0]  last_b = 8'h00;

   int n_tests = 0;
   int n_fail  = 0;

   // Snapshot of outputs taken just after an asynchronous reset assertion
   logic [19:0] obs      = 20'h0;
   int          obs_seq  = 0;
   int          obs_seen = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model update at each rising edge, scoreboard checks at each falling edge.
   always @(posedge clk or negedge clk or negedge rst_n) begin
      exp_t e;
      logic exp_v;
      if (obs_seq != obs_seen) begin
         check("async reset clears ready/rd_valid/rd_data", 32'(obs), 32'h0);
         obs_seen = obs_seq;
      end
      if (!rst_n) begin
         m_ready    = 1'b0;
         sweep_left = 256;
         qa.delete();
         qb.delete();
         last_a = 8'h00;
         last_b = 8'h00;
         foreach (m_mem[i]) m_mem[i] = 8'h00;
      end else if (clk) begin
         cyc++;
         if (!m_ready) begin
            sweep_left--;
            if (sweep_left == 0) m_ready = 1'b1;
         end else if (clr) begin
            m_ready    = 1'b0;
            sweep_left = 256;
            foreach (m_mem[i]) m_mem[i] = 8'h00;
            while (qa.size() > 0 && qa[$].due >= 32'(cyc)) void'(qa.pop_back());
            while (qb.size() > 0 && qb[$].due >= 32'(cyc)) void'(qb.pop_back());
         end else begin
            if (rd_en) begin
               e.data = (wr_en && wr_addr == rd_addr) ? wr_data : m_mem[rd_addr];
               e.due  = 32'(cyc);
               qa.push_back(e);
               e.data = m_mem[rd_addr];
               e.due  = 32'(cyc) + 32'd1;
               qb.push_back(e);
            end
            if (wr_en) m_mem[wr_addr] = wr_data;
         end
      end else begin
         check("ready A", 32'(ready_a), 32'(m_ready));
         check("ready B", 32'(ready_b), 32'(m_ready));

         exp_v = (qa.size() > 0) && (qa[0].due == 32'(cyc));
         check("rd_valid A", 32'(rd_valid_a), 32'(exp_v));
         if (exp_v) begin
            e      = qa.pop_front();
            last_a = e.data;
         end
         check("rd_data A", 32'(rd_data_a), 32'(last_a));

         exp_v = (qb.size() > 0) && (qb[0].due == 32'(cyc));
         check("rd_valid B", 32'(rd_valid_b), 32'(exp_v));
         if (exp_v) begin
            e      = qb.pop_front();
            last_b = e.data;
         end
         check("rd_data B", 32'(rd_data_b), 32'(last_b));
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic drv(input logic we, input logic [7:0] wa, input logic [7:0] wd,
                      input logic re, input logic [7:0] ra, input logic c);
      step();
      wr_en   = we;
      wr_addr = wa;
      wr_data = wd;
      rd_en   = re;
      rd_addr = ra;
      clr     = c;
   endtask

   task automatic idle();
      drv(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic rd(input logic [7:0] a);
      drv(1'b0, 8'h00, 8'h00, 1'b1, a, 1'b0);
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      drv(1'b1, a, d, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic wait_ready(input int bound);
      for (int i = 0; i < bound; i++) begin
         step();
         if (ready_a && ready_b) return;
      end
      $display("FAIL wait_ready: ready=%0b/%0b after %0d cycles, expected 1", ready_a, ready_b, bound);
      $fatal(1, "ready timeout");
   endtask

   initial begin
      logic [7:0] wa, ra;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      wait_ready(300);

      // Freshly swept memory reads zero at both ends
      rd(8'h00);
      rd(8'hFF);
      idle();

      // Simple write then read
      wr(8'h10, 8'hA5);
      rd(8'h10);
      idle();

      // Same-edge collision, then a later read of the new value
      wr(8'h20, 8'h11);
      drv(1'b1, 8'h20, 8'h3C, 1'b1, 8'h20, 1'b0);
      rd(8'h20);
      idle();

      // Random traffic concentrated on a few addresses to provoke collisions
      for (int i = 0; i < 400; i++) begin
         wa = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
         ra = ($urandom_range(0, 3) == 0) ? wa : 8'($urandom_range(0, 15));
         drv(1'($urandom_range(0, 1)), wa, 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), ra, 1'b0);
      end
      idle();

      // Back-to-back read burst
      for (int i = 0; i < 16; i++) rd(8'(i));
      idle();

      // Fill, clear with accesses attempted during the sweep, then verify all zero
      for (int i = 0; i < 256; i++) wr(8'(i), 8'h5A);
      rd(8'h33);
      drv(1'b1, 8'h05, 8'h77, 1'b1, 8'h05, 1'b1);
      repeat (5) drv(1'b1, 8'h05, 8'h77, 1'b1, 8'h05, 1'b0);
      idle();
      wait_ready(300);
      for (int i = 0; i < 256; i++) rd(8'(i));
      idle();

      // Read burst interrupted by a clear request
      for (int i = 0; i < 16; i++) wr(8'(i), 8'(8'hC0 + i));
      for (int i = 0; i < 16; i++) drv(1'b0, 8'h00, 8'h00, 1'b1, 8'(i), i == 8);
      idle();
      wait_ready(300);
      rd(8'h03);
      idle();

      // Asynchronous reset in the middle of a sweep
      wr(8'h10, 8'h99);
      rd(8'h10);
      idle();
      idle();
      drv(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
      idle();
      repeat (128) step();
      rst_n = 1'b0;
      #1;
      obs = {ready_a, ready_b, rd_valid_a, rd_valid_b, rd_data_a, rd_data_b};
      obs_seq++;
      repeat (3) step();
      rst_n = 1'b1;
      wait_ready(300);
      rd(8'h10);
      rd(8'h80);
      rd(8'hFF);
      idle();
      idle();
      idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
